dr4_word_decoder: RTL and testbench

DR4_WORD_DECODER -- requirements
Module: dr4_word_decoder

---
 rtl/dr4_pkg.sv | 17 +
 rtl/dr4_sym_decode.sv | 21 ++
 rtl/dr4_word_decoder.sv | 109 ++++++++++
 tb/tb_dr4_word_decoder.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/dr4_pkg.sv
// Shared definitions for the dual-rail (DR4) symbol encoder/decoder pair.
package dr4_pkg;

  localparam int unsigned SYM_W = 2;

  // Symbol codes as {b1,b0}
  localparam logic [SYM_W-1:0] SYM_0 = 2'b00;
  localparam logic [SYM_W-1:0] SYM_1 = 2'b01;
  localparam logic [SYM_W-1:0] SYM_X = 2'b10;
  localparam logic [SYM_W-1:0] SYM_Z = 2'b11;

  typedef enum logic {
    COLLECT = 1'b0,
    HOLD    = 1'b1
  } dr4_state_t;

endpackage

// File: rtl/dr4_sym_decode.sv
// Combinational decode of one {b1,b0} symbol into a logic value plus X/Z flags.
module dr4_sym_decode
  import dr4_pkg::*;
(
  input  logic b1,
  input  logic b0,
  output logic val,
  output logic is_x,
  output logic is_z
);

  logic [SYM_W-1:0] sym;

  always_comb begin
    sym  = {b1, b0};
    val  = (sym == SYM_1);
    is_x = (sym == SYM_X);
    is_z = (sym == SYM_Z);
  end

endmodule

// File: rtl/dr4_word_decoder.sv
// Packs accepted DR4 symbols LSB-first into a word with X/Z masks and hands it
// downstream over a valid/ready interface.
module dr4_word_decoder
  import dr4_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CW    = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             s_valid,
  input  logic             s_b1,
  input  logic             s_b0,
  input  logic             s_last,
  output logic             s_ready,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [WIDTH-1:0] m_data,
  output logic [WIDTH-1:0] m_xmask,
  output logic [WIDTH-1:0] m_zmask,
  output logic [CW-1:0]    m_count,
  output logic             m_unknown
);

  dr4_state_t       state;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] acc_data;
  logic [WIDTH-1:0] acc_x;
  logic [WIDTH-1:0] acc_z;

  logic             sym_val;
  logic             sym_x;
  logic             sym_z;
  logic             accept;
  logic             word_done;
  logic [WIDTH-1:0] pos;
  logic [WIDTH-1:0] nxt_data;
  logic [WIDTH-1:0] nxt_x;
  logic [WIDTH-1:0] nxt_z;

  dr4_sym_decode u_sym_decode (
    .b1   (s_b1),
    .b0   (s_b0),
    .val  (sym_val),
    .is_x (sym_x),
    .is_z (sym_z)
  );

  // Accumulators with the current symbol merged in at bit position cnt
  always_comb begin
    accept    = s_valid & s_ready;
    pos       = WIDTH'(1) << cnt;
    nxt_data  = acc_data | ({WIDTH{sym_val}} & pos);
    nxt_x     = acc_x    | ({WIDTH{sym_x}}   & pos);
    nxt_z     = acc_z    | ({WIDTH{sym_z}}   & pos);
    word_done = accept & (s_last | (cnt == CW'(WIDTH - 1)));
  end

  // s_ready comes up on the first clock after reset and tracks COLLECT thereafter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= COLLECT;
      cnt       <= '0;
      acc_data  <= '0;
      acc_x     <= '0;
      acc_z     <= '0;
      s_ready   <= 1'b0;
      m_valid   <= 1'b0;
      m_data    <= '0;
      m_xmask   <= '0;
      m_zmask   <= '0;
      m_count   <= '0;
      m_unknown <= 1'b0;
    end else if (state == COLLECT) begin
      s_ready <= 1'b1;
      if (word_done) begin
        m_data    <= nxt_data;
        m_xmask   <= nxt_x;
        m_zmask   <= nxt_z;
        m_count   <= cnt + CW'(1);
        m_unknown <= |(nxt_x | nxt_z);
        m_valid   <= 1'b1;
        s_ready   <= 1'b0;
        state     <= HOLD;
        cnt       <= '0;
        acc_data  <= '0;
        acc_x     <= '0;
        acc_z     <= '0;
      end else if (accept) begin
        acc_data <= nxt_data;
        acc_x    <= nxt_x;
        acc_z    <= nxt_z;
        cnt      <= cnt + CW'(1);
      end
    end else begin
      // HOLD: outputs frozen until the downstream handshake
      if (m_ready) begin
        m_valid  <= 1'b0;
        s_ready  <= 1'b1;
        state    <= COLLECT;
        cnt      <= '0;
        acc_data <= '0;
        acc_x    <= '0;
        acc_z    <= '0;
      end
    end
  end

endmodule

// File: tb/tb_dr4_word_decoder.sv
// Self-checking bench for dr4_word_decoder (WIDTH=8): directed vector table,
// hold/reset sequences and a randomized valid/ready run against a word scoreboard.
module tb_dr4_word_decoder;

  localparam int unsigned WIDTH = 8;
  localparam int unsigned CW    = 4;

  typedef struct packed {
    logic [WIDTH-1:0] d;
    logic [WIDTH-1:0] x;
    logic [WIDTH-1:0] z;
    logic [CW-1:0]    c;
    logic             u;
  } word_t;

  typedef struct {
    logic [1:0] sym [8];
    int         n;
    logic       last;
    word_t      exp;
  } vec_t;

  logic             clk;
  logic             rst_n;
  logic             s_valid;
  logic             s_b1;
  logic             s_b0;
  logic             s_last;
  logic             s_ready;
  logic             m_valid;
  logic             m_ready;
  logic [WIDTH-1:0] m_data;
  logic [WIDTH-1:0] m_xmask;
  logic [WIDTH-1:0] m_zmask;
  logic [CW-1:0]    m_count;
  logic             m_unknown;

  int tests = 0;
  int fails = 0;

  dr4_word_decoder #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .s_valid   (s_valid),
    .s_b1      (s_b1),
    .s_b0      (s_b0),
    .s_last    (s_last),
    .s_ready   (s_ready),
    .m_valid   (m_valid),
    .m_ready   (m_ready),
    .m_data    (m_data),
    .m_xmask   (m_xmask),
    .m_zmask   (m_zmask),
    .m_count   (m_count),
    .m_unknown (m_unknown)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic word_t cur_word();
    return '{m_data, m_xmask, m_zmask, m_count, m_unknown};
  endfunction

  task automatic chk_word(input string tag, input word_t e);
    chk({tag, ".m_data"},    32'(m_data),    32'(e.d));
    chk({tag, ".m_xmask"},   32'(m_xmask),   32'(e.x));
    chk({tag, ".m_zmask"},   32'(m_zmask),   32'(e.z));
    chk({tag, ".m_count"},   32'(m_count),   32'(e.c));
    chk({tag, ".m_unknown"}, 32'(m_unknown), 32'(e.u));
  endtask

  // Reference: word value built directly from the symbol meanings
  function automatic word_t ref_word(input logic [1:0] syms [8], input int n);
    word_t w;
    w = '0;
    for (int k = 0; k < n; k++) begin
      case (syms[k])
        2'b01:   w.d = w.d + WIDTH'(1 << k);
        2'b10:   w.x = w.x + WIDTH'(1 << k);
        2'b11:   w.z = w.z + WIDTH'(1 << k);
        default: ;
      endcase
    end
    w.c = CW'(n);
    w.u = (w.x != 0) || (w.z != 0);
    return w;
  endfunction

  task automatic send_sym(input logic [1:0] sym, input logic last);
    s_valid = 1'b1;
    {s_b1, s_b0} = sym;
    s_last = last;
    @(posedge clk); #1;
    s_valid = 1'b0;
    s_last  = 1'b0;
  endtask

  vec_t  vecs [7];
  word_t held;

  // Randomized-run state
  logic [1:0] rsym [$];
  logic       rlast [$];
  word_t      exp_q [$];
  logic [1:0] wsyms [8];

  initial begin
    rst_n = 1'b0; s_valid = 1'b0; s_b1 = 1'b0; s_b0 = 1'b0; s_last = 1'b0; m_ready = 1'b1;

    vecs[0] = '{sym: '{2'b01,2'b00,2'b01,2'b01,2'b00,2'b00,2'b00,2'b01}, n: 8, last: 1'b0,
                exp: '{8'h8D, 8'h00, 8'h00, 4'd8, 1'b0}};
    vecs[1] = '{sym: '{2'b01,2'b10,2'b11,2'b00,2'b00,2'b00,2'b00,2'b00}, n: 4, last: 1'b1,
                exp: '{8'h01, 8'h02, 8'h04, 4'd4, 1'b1}};
    vecs[2] = '{sym: '{2'b11,2'b00,2'b00,2'b00,2'b00,2'b00,2'b00,2'b00}, n: 1, last: 1'b1,
                exp: '{8'h00, 8'h00, 8'h01, 4'd1, 1'b1}};
    vecs[3] = '{sym: '{2'b10,2'b10,2'b10,2'b10,2'b10,2'b10,2'b10,2'b10}, n: 8, last: 1'b1,
                exp: '{8'h00, 8'hFF, 8'h00, 4'd8, 1'b1}};
    vecs[4] = '{sym: '{2'b00,2'b01,2'b00,2'b00,2'b00,2'b00,2'b00,2'b00}, n: 2, last: 1'b1,
                exp: '{8'h02, 8'h00, 8'h00, 4'd2, 1'b0}};
    vecs[5] = '{sym: '{2'b01,2'b01,2'b01,2'b01,2'b01,2'b01,2'b01,2'b01}, n: 8, last: 1'b0,
                exp: '{8'hFF, 8'h00, 8'h00, 4'd8, 1'b0}};
    vecs[6] = '{sym: '{2'b11,2'b01,2'b10,2'b00,2'b00,2'b00,2'b00,2'b00}, n: 3, last: 1'b1,
                exp: '{8'h02, 8'h04, 8'h01, 4'd3, 1'b1}};

    // Reset values
    repeat (3) @(posedge clk);
    #1;
    chk_word("reset", '0);
    chk("reset.m_valid", 32'(m_valid), 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("post_reset.s_ready", 32'(s_ready), 32'd1);
    chk("post_reset.m_valid", 32'(m_valid), 32'd0);

    // Directed vector table, m_ready held high
    for (int i = 0; i < 7; i++) begin
      for (int k = 0; k < vecs[i].n; k++)
        send_sym(vecs[i].sym[k], vecs[i].last && (k == vecs[i].n - 1));
      chk($sformatf("vec%0d.m_valid_latency", i), 32'(m_valid), 32'd1);
      chk($sformatf("vec%0d.s_ready_hold", i), 32'(s_ready), 32'd0);
      chk_word($sformatf("vec%0d", i), vecs[i].exp);
      for (int c = 0; c < 3; c++) begin
        @(posedge clk); #1;
        chk($sformatf("vec%0d.single_word", i), 32'(m_valid), 32'd0);
        chk($sformatf("vec%0d.s_ready_back", i), 32'(s_ready), 32'd1);
      end
    end

    // Back-pressure: word held for 5 cycles while upstream keeps offering junk
    m_ready = 1'b0;
    for (int k = 0; k < 8; k++) send_sym(vecs[0].sym[k], 1'b0);
    for (int c = 0; c < 5; c++) begin
      s_valid = 1'b1; s_b1 = 1'b1; s_b0 = 1'b1; s_last = 1'b1;
      chk("hold.m_valid", 32'(m_valid), 32'd1);
      chk("hold.s_ready", 32'(s_ready), 32'd0);
      chk_word("hold", vecs[0].exp);
      @(posedge clk); #1;
    end
    s_valid = 1'b0; s_last = 1'b0;
    chk_word("hold_end", vecs[0].exp);
    m_ready = 1'b1;
    @(posedge clk); #1;
    chk("hold_release.m_valid", 32'(m_valid), 32'd0);
    chk("hold_release.s_ready", 32'(s_ready), 32'd1);

    // Reset in the middle of a word discards it
    for (int k = 0; k < 5; k++) send_sym(2'b01, 1'b0);
    rst_n = 1'b0;
    #1;
    chk("midreset.m_valid", 32'(m_valid), 32'd0);
    @(posedge clk); #1;
    chk_word("midreset", '0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("midreset.s_ready", 32'(s_ready), 32'd1);
    @(posedge clk); #1;
    chk("midreset.no_pulse", 32'(m_valid), 32'd0);
    for (int k = 0; k < 8; k++) send_sym((k == 7) ? 2'b11 : 2'b00, 1'b0);
    chk("midreset.m_valid", 32'(m_valid), 32'd1);
    chk_word("midreset_word", '{8'h00, 8'h00, 8'h80, 4'd8, 1'b1});
    @(posedge clk); #1;

    // Randomized run: 20 words, random s_valid/m_ready, junk on idle symbol lines
    for (int w = 0; w < 20; w++) begin
      int len;
      logic end_last;
      len = int'($urandom_range(1, 8));
      end_last = (len < 8) || ($urandom_range(0, 1) == 1);
      for (int k = 0; k < 8; k++) wsyms[k] = 2'b00;
      for (int k = 0; k < len; k++) begin
        wsyms[k] = 2'($urandom_range(0, 3));
        rsym.push_back(wsyms[k]);
        rlast.push_back((k == len - 1) && end_last);
      end
      exp_q.push_back(ref_word(wsyms, len));
    end

    begin
      int   idx = 0;
      int   pos = 0;
      int   cyc = 0;
      int   nwords = 0;
      logic exp_valid_now = 1'b0;
      logic exp_valid_next = 1'b0;
      logic was_held = 1'b0;
      while ((idx < rsym.size() || exp_q.size() > 0) && cyc < 3000) begin
        cyc++;
        if (idx < rsym.size() && $urandom_range(0, 2) != 0) begin
          s_valid = 1'b1;
          {s_b1, s_b0} = rsym[idx];
          s_last = rlast[idx];
        end else begin
          s_valid = 1'b0;
          s_b1 = 1'($urandom); s_b0 = 1'($urandom); s_last = 1'($urandom);
        end
        m_ready = ($urandom_range(0, 3) != 0);
        #1;
        if (exp_valid_now) chk("rand.latency", 32'(m_valid), 32'd1);
        if (was_held) chk("rand.hold_stable", 32'(cur_word()), 32'(held));
        was_held = 1'b0;
        if (m_valid && m_ready) begin
          if (exp_q.size() == 0) begin
            chk("rand.extra_word", 32'(m_valid), 32'd0);
          end else begin
            chk_word($sformatf("rand.word%0d", nwords), exp_q.pop_front());
            nwords++;
          end
        end else if (m_valid) begin
          was_held = 1'b1;
          held = cur_word();
        end
        if (s_valid && s_ready) begin
          pos++;
          if (rlast[idx] || pos == 8) begin
            pos = 0;
            exp_valid_next = 1'b1;
          end
          idx++;
        end
        @(posedge clk); #1;
        exp_valid_now = exp_valid_next;
        exp_valid_next = 1'b0;
      end
      s_valid = 1'b0; s_last = 1'b0;
      chk("rand.timeout", 32'(cyc < 3000), 32'd1);
      chk("rand.words_out", 32'(nwords), 32'd20);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
